// File: rtl/fp_pkg.sv
// Shared FP encodings, canonical NaN constants and format helpers
// for the sign-injection datapath.
package fp_pkg;

    typedef enum logic [1:0] {
        FMT_S = 2'b00,
        FMT_D = 2'b01,
        FMT_H = 2'b10,
        FMT_R = 2'b11
    } fp_fmt_e;

    typedef enum logic [1:0] {
        SGNJ_OP_J   = 2'b00,
        SGNJ_OP_N   = 2'b01,
        SGNJ_OP_X   = 2'b10,
        SGNJ_OP_ABS = 2'b11
    } sgnj_op_e;

    localparam logic [31:0] CNAN_S = 32'h7FC0_0000;
    localparam logic [15:0] CNAN_H = 16'h7E00;

    // Reserved format and double on a 32-bit register file collapse to single.
    function automatic fp_fmt_e fmt_resolve(input logic [1:0] fmt, input int flen);
        fp_fmt_e res;
        case (fmt)
            2'b00:   res = FMT_S;
            2'b01:   res = (flen == 64) ? FMT_D : FMT_S;
            2'b10:   res = FMT_H;
            default: res = FMT_S;
        endcase
        return res;
    endfunction

    function automatic logic [6:0] fmt_width(input fp_fmt_e fmt, input int flen);
        logic [6:0] w;
        case (fmt)
            FMT_S:   w = 7'd32;
            FMT_D:   w = 7'(flen);
            FMT_H:   w = 7'd16;
            default: w = 7'd32;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fsgnj_pipe_if.sv
// Issue/result handshake bundle between the FALU issue slot and the
// sign-injection pipe.
interface fsgnj_pipe_if #(
    parameter int FLEN  = 64,
    parameter int TAG_W = 6
);
    logic             FLUSH;
    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       IN_FMT;
    logic [1:0]       IN_OP;
    logic [TAG_W-1:0] IN_TAG;
    logic [FLEN-1:0]  INPUT_1;
    logic [FLEN-1:0]  INPUT_2;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [TAG_W-1:0] OUT_TAG;
    logic [FLEN-1:0]  OUTPUT;

    modport master (
        output FLUSH, IN_VALID, IN_FMT, IN_OP, IN_TAG, INPUT_1, INPUT_2, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_TAG, OUTPUT
    );

    modport slave (
        input  FLUSH, IN_VALID, IN_FMT, IN_OP, IN_TAG, INPUT_1, INPUT_2, OUT_READY,
        output IN_READY, OUT_VALID, OUT_TAG, OUTPUT
    );
endinterface

// File: rtl/fp_nanbox_unbox.sv
// NaN-box check of one operand: narrow values whose upper bits are not all
// ones are replaced by the canonical NaN of their format.
module fp_nanbox_unbox
    import fp_pkg::*;
#(
    parameter int FLEN = 64
) (
    input  logic [FLEN-1:0] i_val,
    input  fp_fmt_e         i_fmt,
    output logic [FLEN-1:0] o_val
);

    logic [6:0]      w_width;
    logic [FLEN-1:0] w_box_mask;
    logic [FLEN-1:0] w_cnan;
    logic            w_boxed;

    // Box mask covers bits above the format width; empty for full-width double.
    always_comb begin
        w_width    = fmt_width(i_fmt, FLEN);
        w_box_mask = {FLEN{1'b1}} << w_width;
        case (i_fmt)
            FMT_H:   w_cnan = FLEN'(CNAN_H);
            default: w_cnan = FLEN'(CNAN_S);
        endcase
        w_boxed = ((i_val & w_box_mask) == w_box_mask);
        if (w_boxed) begin
            o_val = i_val & ~w_box_mask;
        end else begin
            o_val = w_cnan;
        end
    end

endmodule

// File: rtl/fsgnj_pipe_chk.sv
// Protocol and configuration properties observed on the sign-injection pipe.
module fsgnj_pipe_chk
    import fp_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 6
) (
    input logic             CLK,
    input logic             RST,
    input logic             FLUSH,
    input logic             IN_VALID,
    input logic [1:0]       IN_FMT,
    input logic             OUT_VALID,
    input logic             OUT_READY,
    input logic [TAG_W-1:0] OUT_TAG,
    input logic [FLEN-1:0]  OUTPUT
);

    a_latency_legal: assert property (@(posedge CLK) (LATENCY >= 1) && (LATENCY <= 3));

    a_no_double_on_32: assert property (@(posedge CLK) disable iff (RST)
        (IN_VALID && (FLEN == 32)) |-> (IN_FMT != FMT_D));

    a_flush_clears: assert property (@(posedge CLK) disable iff (RST)
        FLUSH |=> !OUT_VALID);

    a_stall_stable: assert property (@(posedge CLK) disable iff (RST)
        (OUT_VALID && !OUT_READY && !FLUSH) |=>
            (OUT_VALID && $stable(OUTPUT) && $stable(OUT_TAG)));

endmodule

// File: rtl/fsgnj_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX/FABS for half, single and double with
// NaN-boxed results, valid/ready stall chain, ROB tag and flush.
module fsgnj_pipe
    import fp_pkg::*;
#(
    parameter int FLEN    = 64,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 6
) (
    input logic         CLK,
    input logic         RST,
    fsgnj_pipe_if.slave bus
);

    fp_fmt_e         w_fmt;
    sgnj_op_e        w_op;
    logic [6:0]      w_width;
    logic [FLEN-1:0] w_op1;
    logic [FLEN-1:0] w_op2;
    logic [FLEN-1:0] w_box_mask;
    logic [FLEN-1:0] w_mag_mask;
    logic [FLEN-1:0] w_sign_mask;
    logic            w_s1;
    logic            w_s2;
    logic            w_sign;
    logic [FLEN-1:0] w_result;

    logic [LATENCY-1:0] w_adv;
    logic [LATENCY-1:0] r_vld;
    logic [FLEN-1:0]    r_data [LATENCY];
    logic [TAG_W-1:0]   r_tag  [LATENCY];

    // Decode format and operation for the stage-0 datapath.
    always_comb begin
        w_fmt   = fmt_resolve(bus.IN_FMT, FLEN);
        w_op    = sgnj_op_e'(bus.IN_OP);
        w_width = fmt_width(w_fmt, FLEN);
    end

    fp_nanbox_unbox #(.FLEN(FLEN)) u_unbox_1 (
        .i_val (bus.INPUT_1),
        .i_fmt (w_fmt),
        .o_val (w_op1)
    );

    fp_nanbox_unbox #(.FLEN(FLEN)) u_unbox_2 (
        .i_val (bus.INPUT_2),
        .i_fmt (w_fmt),
        .o_val (w_op2)
    );

    // The sign lives at bit W-1; selecting it by mask avoids a variable bit index.
    always_comb begin
        w_box_mask  = {FLEN{1'b1}} << w_width;
        w_mag_mask  = ~({FLEN{1'b1}} << (w_width - 7'd1));
        w_sign_mask = ~w_mag_mask & ~w_box_mask;
        w_s1        = |(w_op1 & w_sign_mask);
        w_s2        = |(w_op2 & w_sign_mask);
        case (w_op)
            SGNJ_OP_J:   w_sign = w_s2;
            SGNJ_OP_N:   w_sign = ~w_s2;
            SGNJ_OP_X:   w_sign = w_s1 ^ w_s2;
            SGNJ_OP_ABS: w_sign = 1'b0;
            default:     w_sign = w_s2;
        endcase
        w_result = w_box_mask
                 | (w_sign ? w_sign_mask : {FLEN{1'b0}})
                 | (w_op1 & w_mag_mask);
    end

    // Advance chain, resolved from the output back towards stage 0.
    always_comb begin
        w_adv = {LATENCY{1'b0}};
        w_adv[LATENCY-1] = ~r_vld[LATENCY-1] | bus.OUT_READY;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            w_adv[k] = ~r_vld[k] | w_adv[k+1];
        end
    end

    // Stage registers: stage 0 captures results, later stages only shift.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld <= {LATENCY{1'b0}};
            for (int k = 0; k < LATENCY; k++) begin
                r_data[k] <= {FLEN{1'b0}};
                r_tag[k]  <= {TAG_W{1'b0}};
            end
        end else if (bus.FLUSH) begin
            r_vld <= {LATENCY{1'b0}};
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= bus.IN_VALID;
                if (bus.IN_VALID) begin
                    r_data[0] <= w_result;
                    r_tag[0]  <= bus.IN_TAG;
                end
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_data[k] <= r_data[k-1];
                        r_tag[k]  <= r_tag[k-1];
                    end
                end
            end
        end
    end

    assign bus.IN_READY  = w_adv[0];
    assign bus.OUT_VALID = r_vld[LATENCY-1];
    assign bus.OUTPUT    = r_data[LATENCY-1];
    assign bus.OUT_TAG   = r_tag[LATENCY-1];

    fsgnj_pipe_chk #(.FLEN(FLEN), .LATENCY(LATENCY), .TAG_W(TAG_W)) u_chk (
        .CLK       (CLK),
        .RST       (RST),
        .FLUSH     (bus.FLUSH),
        .IN_VALID  (bus.IN_VALID),
        .IN_FMT    (bus.IN_FMT),
        .OUT_VALID (bus.OUT_VALID),
        .OUT_READY (bus.OUT_READY),
        .OUT_TAG   (bus.OUT_TAG),
        .OUTPUT    (bus.OUTPUT)
    );

endmodule

// File: doc/fsgnj_pipe.md
Name: fsgnj_pipe

Overview:
- Parametrised, pipelined FP sign-injection unit: FSGNJ/FSGNJN/FSGNJX/FABS for half, single and double formats.
- Checks NaN-boxing of each narrow operand; writes a NaN-boxed result to the FLEN-wide register file.
- Sits in the FALU issue slot. Uses a valid/ready handshake and carries a ROB tag. Supports pipeline flush on branch mispredict.

Parameters:
- FLEN, 64, FP register width; legal values 32 or 64. Double format is illegal when FLEN=32.
- LATENCY, 1, number of register stages from input to output; legal values 1..3.
- TAG_W, 6, width of the ROB tag carried alongside each operation.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- FLUSH  in  1  synchronous kill of all in-flight operations.
- IN_VALID  in  1  an operation is presented at the input.
- IN_READY  out  1  the unit accepts the operation this cycle.
- IN_FMT  in  2  operand format: 00 single, 01 double, 10 half, 11 reserved (treated as single).
- IN_OP  in  2  operation: 00 SGNJ, 01 SGNJN, 10 SGNJX, 11 ABS (sign forced to 0).
- IN_TAG  in  TAG_W  ROB tag of the operation.
- INPUT_1  in  FLEN  rs1 value; supplies magnitude, and sign for SGNJX.
- INPUT_2  in  FLEN  rs2 value; supplies the sign source.
- OUT_VALID  out  1  a result is presented at the output.
- OUT_READY  in  1  downstream consumes the result this cycle.
- OUT_TAG  out  TAG_W  ROB tag of the result.
- OUTPUT  out  FLEN  NaN-boxed result.

Behaviour:
- Reset: all stage valid bits are 0, so OUT_VALID=0 and IN_READY=1. OUTPUT and OUT_TAG reset to 0. Reset asserted mid-operation discards everything in flight.
- Accept: an operation is accepted when IN_VALID & IN_READY.
- NaN-box check for narrow format width W (32 or 16): the operand is valid iff INPUT[FLEN-1:W] is all ones. An invalid operand is replaced by the canonical NaN: 0x7FC00000 (single), 0x7E00 (half). The check is performed independently for each operand.
- Sign source bit is W-1 of the checked operand:
  - SGNJ: sign = s2.
  - SGNJN: sign = ~s2.
  - SGNJX: sign = s1 ^ s2.
  - ABS: sign = 0.
- Result = {ones[FLEN-1:W], sign, op1[W-2:0]}. For double, W=FLEN and no box bits are added.
- Computation happens in stage 0; later stages only carry data.
- Latency: with no stalls, an operation accepted at edge N appears with OUT_VALID=1 after edge N+LATENCY-1, i.e. LATENCY cycles after IN_VALID is sampled.
- Stage advance: stage k advances when it is empty or stage k+1 advances. The last stage advances when OUT_READY or it is empty.
- IN_READY = stage 0 empty or stage 0 advances. This is combinational from OUT_READY through the chain; there is no skid buffer.
- Stall: when OUT_VALID & ~OUT_READY, OUTPUT and OUT_TAG stay stable until consumed.
- Back-to-back: full throughput of one operation per cycle while OUT_READY=1.
- FLUSH: every stage valid bit clears at the next edge.
  - An input presented in the same cycle as FLUSH is dropped, even though IN_READY may be 1.
  - OUT_VALID is 0 in the cycle after FLUSH.
- Reserved format 11 behaves as single. Selecting double with FLEN=32 is caught by a simulation assertion and behaves as single.

Decomposition:
- Shared package fp_pkg holds:
  - format encodings FMT_S/FMT_D/FMT_H;
  - op encodings SGNJ_OP_J/N/X/ABS;
  - canonical NaN constants CNAN_S=32'h7FC00000 and CNAN_H=16'h7E00;
  - a function that returns the format width.
- One sub-module, fp_nanbox_unbox: a combinational NaN-box check and canonicalisation, instantiated once per operand.
- Pipeline control (valid bits, advance chain) stays in fsgnj_pipe.

Test Plan:
- LATENCY=2, FLEN=64, double SGNJN with INPUT_1=0x3FF0000000000000 and INPUT_2=0x4000000000000000 → OUTPUT=0xBFF0000000000000 with OUT_VALID=1 two cycles after accept.
- Single SGNJX with INPUT_1=0xFFFFFFFFBF800000 and INPUT_2=0xFFFFFFFFC0000000 → OUTPUT=0xFFFFFFFF3F800000.
- Single SGNJ with INPUT_1=0x00000000_3F800000 (bad box) and INPUT_2=0xFFFFFFFF80000000 → OUTPUT=0xFFFFFFFFFFC00000; half ABS with INPUT_1=0x...FFFF_BC00 → 0xFFFFFFFFFFFF3C00.
- Stream 4 ops while OUT_READY is held at 0 for 3 cycles → IN_READY drops once all LATENCY stages are full, OUTPUT stays stable, then all 4 results emerge in order with their tags and none are lost or duplicated.
- FLUSH with 2 ops in flight plus IN_VALID the same cycle → OUT_VALID=0 next cycle and none of the 3 ops appear. RST asserted asynchronously mid-stream → OUT_VALID falls immediately and OUTPUT=0.
